tpu_cmd_bridge: RTL and testbench
=================================

TPU_CMD_BRIDGE -- requirements
Module: tpu_cmd_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the maximum idle gap in cycles between bytes inside one frame.
REQ-002 The block SHALL have parameter ADDR_LO, default 8'h20, giving the lowest accepted register address.
REQ-003 The block SHALL have parameter ADDR_HI, default 8'h24, giving the highest accepted register address.
REQ-004 Port SYS_CLK input 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port RST input 1: reset, synchronous and active-high.
REQ-006 Port rx_data input 8: received serial byte.
REQ-007 Port rx_valid input 1: rx_data is valid this cycle; one byte SHALL be consumed per asserted cycle.
REQ-008 Port addr output 8: register address towards the TPU.
REQ-009 Port data output 8: register write data towards the TPU data_in.
REQ-010 Port valid output 1: single-cycle write strobe towards the TPU.
REQ-011 Port err_chk output 1: single-cycle pulse on a checksum mismatch.
REQ-012 Port err_addr output 1: single-cycle pulse on an out-of-range address.
REQ-013 Port err_timeout output 1: single-cycle pulse on an inter-byte timeout.
REQ-014 Port frame_cnt output 8: count of good frames, wrapping modulo 256.

Function
REQ-015 A frame SHALL consist of four bytes, in order: SYNC = 8'hA5, ADDR, DATA, CHK.
REQ-016 CHK SHALL equal (ADDR + DATA) mod 256; the sum SHALL be 8-bit and the carry discarded.
REQ-017 The FSM SHALL have exactly four states, IDLE, ADDR, DATA and CHK, each named for the byte it expects next.
REQ-018 IDLE: a byte equal to 8'hA5 SHALL move to ADDR; any other byte SHALL be discarded with no error pulse.
REQ-019 ADDR: the byte SHALL be stored as the pending address, then the FSM SHALL move to DATA.
REQ-020 DATA: the byte SHALL be stored as the pending data, then the FSM SHALL move to CHK.
REQ-021 CHK: the byte SHALL be evaluated, then the FSM SHALL return to IDLE.
REQ-022 Inside a frame, 8'hA5 SHALL be treated as ordinary payload; there SHALL be no mid-frame resync.
REQ-023 Good frame: CHK matches and ADDR_LO <= ADDR <= ADDR_HI.
- addr and data SHALL update to the pending values, and valid SHALL be high, in the cycle after the CHK byte is accepted (1-cycle latency).
- frame_cnt SHALL increment in that same cycle.
REQ-024 Checksum mismatch: err_chk SHALL pulse 1 cycle after the CHK byte, valid SHALL stay low, and addr/data SHALL be unchanged.
REQ-025 Correct checksum but address out of range: err_addr SHALL pulse 1 cycle after the CHK byte, valid SHALL stay low, and addr/data SHALL be unchanged.
REQ-026 Checksum mismatch and bad address together: only err_chk SHALL pulse.
REQ-027 addr and data SHALL hold their last written values between strobes.
REQ-028 valid SHALL never be high for more than one consecutive cycle per frame.
REQ-029 Back-to-back frames with no gap SHALL each produce their own strobe.
REQ-030 Timeout counter:
- The counter SHALL be cleared on every rx_valid and held at 0 in IDLE.
- It SHALL count cycles without rx_valid in ADDR, DATA and CHK.
- On reaching TIMEOUT_CYCLES, the FSM SHALL go to IDLE, err_timeout SHALL pulse 1 cycle, and the partial frame SHALL be dropped.
REQ-031 If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, rx_valid SHALL win: the byte is processed and no timeout occurs.
REQ-032 The counter width SHALL be sufficient for TIMEOUT_CYCLES, and the counter SHALL saturate rather than wrap.
REQ-033 frame_cnt SHALL wrap from 255 to 0 without any flag.
REQ-034 At most one of valid, err_chk, err_addr and err_timeout SHALL be high in any cycle.

Reset
REQ-035 With RST high at a clock edge, the block SHALL set state = IDLE, addr = 0, data = 0, valid = 0, all err_* = 0, frame_cnt = 0, timeout counter = 0, and pending registers = 0.
REQ-036 RST SHALL override rx_valid in the same cycle.
REQ-037 A frame in progress when RST asserts SHALL be discarded with no strobe and no error pulse.
REQ-038 After RST deasserts, the first rx_valid cycle SHALL be processed.

Verification
REQ-039 Good-frame scenario:
- Stimulus: A5, 21, 64, 85.
- Response: addr = 8'h21, data = 8'd100, valid high for 1 cycle, one cycle after the 85 byte; frame_cnt = 1.
REQ-040 Back-to-back scenario:
- Stimulus: A5, 22, C8, EA, then A5, 20, 0F, 2F with no gap.
- Response: two strobes, 4 cycles apart, writing 22 <- C8 then 20 <- 0F; frame_cnt = 2.
REQ-041 Error-frame scenario:
- Stimulus: A5, 21, 64, 00 -> err_chk pulse only.
- Stimulus: A5, 30, 01, 31 -> err_addr pulse only.
- In both cases addr/data are unchanged.
REQ-042 Timeout scenario:
- Stimulus: A5, 23, then silence; TIMEOUT_CYCLES = 10.
- Response: err_timeout pulses at the 10th idle cycle.
- Follow-up: A5, 23, 10, 33 -> write 23 <- 10.
REQ-043 Garbage-and-reset scenario:
- Stimulus: 00, FF before A5, 24, 01, 25 -> single write 24 <- 01 and no error.
- Stimulus: RST asserted after A5, 24 -> no strobe, and frame_cnt returns to 0.

Source files
------------

// File: rtl/tpu_cmd_bridge.sv
// Serial command bridge: parses SYNC/ADDR/DATA/CHK byte frames and issues single-cycle
// register writes towards the TPU, with checksum, address-range and inter-byte timeout errors.
module tpu_cmd_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  ADDR_LO        = 8'h20,
    parameter logic [7:0]  ADDR_HI        = 8'h24
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic       valid,
    output logic       err_chk,
    output logic       err_addr,
    output logic       err_timeout,
    output logic [7:0] frame_cnt
);

    localparam int unsigned     CntW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT_CYCLES);
    localparam logic [7:0]      SyncByte = 8'hA5;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StChk} state_t;

    state_t          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [7:0]      r_addr_pend, w_addr_pend_d;
    logic [7:0]      r_data_pend, w_data_pend_d;
    logic [7:0]      r_addr, w_addr_d;
    logic [7:0]      r_data, w_data_d;
    logic [7:0]      r_frame_cnt, w_frame_cnt_d;
    logic            r_valid, w_valid_d;
    logic            r_err_chk, w_err_chk_d;
    logic            r_err_addr, w_err_addr_d;
    logic            r_err_to, w_err_to_d;
    logic [7:0]      w_sum;
    logic            w_addr_ok;

    assign w_sum     = r_addr_pend + r_data_pend;
    assign w_addr_ok = (r_addr_pend >= ADDR_LO) && (r_addr_pend <= ADDR_HI);

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_addr_pend_d = r_addr_pend;
        w_data_pend_d = r_data_pend;
        w_addr_d      = r_addr;
        w_data_d      = r_data;
        w_frame_cnt_d = r_frame_cnt;
        w_valid_d     = 1'b0;
        w_err_chk_d   = 1'b0;
        w_err_addr_d  = 1'b0;
        w_err_to_d    = 1'b0;

        if (rx_valid) begin
            // A byte always wins over a timeout that would expire on the same edge.
            w_cnt_d = '0;
            unique case (r_state)
                StIdle: if (rx_data == SyncByte) w_state_d = StAddr;
                StAddr: begin
                    w_addr_pend_d = rx_data;
                    w_state_d     = StData;
                end
                StData: begin
                    w_data_pend_d = rx_data;
                    w_state_d     = StChk;
                end
                StChk: begin
                    w_state_d = StIdle;
                    if (rx_data != w_sum) begin
                        w_err_chk_d = 1'b1;
                    end else if (!w_addr_ok) begin
                        w_err_addr_d = 1'b1;
                    end else begin
                        w_valid_d     = 1'b1;
                        w_addr_d      = r_addr_pend;
                        w_data_d      = r_data_pend;
                        w_frame_cnt_d = r_frame_cnt + 8'd1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (r_state != StIdle) begin
            if (r_cnt >= CntLast) begin
                w_state_d  = StIdle;
                w_err_to_d = 1'b1;
                w_cnt_d    = '0;
            end else if (r_cnt != CntMax) begin
                w_cnt_d = r_cnt + CntW'(1);
            end
        end else begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_addr_pend <= 8'd0;
            r_data_pend <= 8'd0;
            r_addr      <= 8'd0;
            r_data      <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_valid     <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_addr  <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_addr_pend <= w_addr_pend_d;
            r_data_pend <= w_data_pend_d;
            r_addr      <= w_addr_d;
            r_data      <= w_data_d;
            r_frame_cnt <= w_frame_cnt_d;
            r_valid     <= w_valid_d;
            r_err_chk   <= w_err_chk_d;
            r_err_addr  <= w_err_addr_d;
            r_err_to    <= w_err_to_d;
        end
    end

    assign addr        = r_addr;
    assign data        = r_data;
    assign valid       = r_valid;
    assign err_chk     = r_err_chk;
    assign err_addr    = r_err_addr;
    assign err_timeout = r_err_to;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tpu_cmd_bridge.sv
// Directed bench for tpu_cmd_bridge; expected flags and register values are hand-computed
// per step and compared with immediate assertions one cycle after each byte edge.
module tb_tpu_cmd_bridge;

    logic       SYS_CLK;
    logic       RST;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       err_chk;
    logic       err_addr;
    logic       err_timeout;
    logic [7:0] frame_cnt;

    int unsigned n_assert;
    int unsigned n_fail;
    logic [7:0]  e_addr;
    logic [7:0]  e_data;
    logic [7:0]  e_fc;

    // Flag encodings {valid, err_chk, err_addr, err_timeout}
    localparam logic [3:0] FNone = 4'b0000;
    localparam logic [3:0] FGood = 4'b1000;
    localparam logic [3:0] FChk  = 4'b0100;
    localparam logic [3:0] FAddr = 4'b0010;
    localparam logic [3:0] FTo   = 4'b0001;

    tpu_cmd_bridge #(
        .TIMEOUT_CYCLES(10)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr       (addr),
        .data       (data),
        .valid      (valid),
        .err_chk    (err_chk),
        .err_addr   (err_addr),
        .err_timeout(err_timeout),
        .frame_cnt  (frame_cnt)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [3:0] ef);
        logic [27:0] obs;
        logic [27:0] exp;
        obs = {valid, err_chk, err_addr, err_timeout, addr, data, frame_cnt};
        exp = {ef, e_addr, e_data, e_fc};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic [3:0] ef);
        rx_valid = v;
        rx_data  = d;
        @(posedge SYS_CLK);
        #1;
        check(tag, ef);
    endtask

    // Sends A5, a, d, c back to back; ef is the hand-computed outcome of the CHK byte.
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] c, input logic [3:0] ef);
        step({tag, "_sync"}, 1'b1, 8'hA5, FNone);
        step({tag, "_addr"}, 1'b1, a, FNone);
        step({tag, "_data"}, 1'b1, d, FNone);
        if (ef == FGood) begin
            e_addr = a;
            e_data = d;
            e_fc   = e_fc + 8'd1;
        end
        step({tag, "_chk"}, 1'b1, c, ef);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        e_addr   = 8'h00;
        e_data   = 8'h00;
        e_fc     = 8'h00;

        // Reset held while a sync byte is presented: reset must win.
        RST      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (2) @(posedge SYS_CLK);
        #1;
        check("reset_state", FNone);
        RST = 1'b0;

        // Good frame: 21 + 64 = 85
        frame("good", 8'h21, 8'h64, 8'h85, FGood);
        step("good_strobe_drop", 1'b0, 8'h00, FNone);
        step("good_hold", 1'b0, 8'h00, FNone);

        // Back-to-back frames, no gap
        frame("b2b_a", 8'h22, 8'hC8, 8'hEA, FGood);
        frame("b2b_b", 8'h20, 8'h0F, 8'h2F, FGood);
        step("b2b_strobe_drop", 1'b0, 8'h00, FNone);

        // Error frames leave addr/data untouched
        frame("bad_chk", 8'h21, 8'h64, 8'h00, FChk);
        frame("bad_addr_hi", 8'h30, 8'h01, 8'h31, FAddr);
        frame("bad_both", 8'h30, 8'h01, 8'h00, FChk);
        frame("bad_addr_below", 8'h1F, 8'h01, 8'h20, FAddr);
        frame("bad_addr_above", 8'h25, 8'h00, 8'h25, FAddr);
        step("err_drop", 1'b0, 8'h00, FNone);

        // A5 as payload, and checksum with discarded carry (24 + F0 = 114)
        frame("payload_a5", 8'h20, 8'hA5, 8'hC5, FGood);
        frame("carry", 8'h24, 8'hF0, 8'h14, FGood);

        // Timeout after A5, 23 with 10 idle cycles
        step("to_sync", 1'b1, 8'hA5, FNone);
        step("to_addr", 1'b1, 8'h23, FNone);
        for (int i = 1; i <= 9; i++) step("to_idle", 1'b0, 8'h00, FNone);
        step("to_fire", 1'b0, 8'h00, FTo);
        step("to_drop", 1'b0, 8'h00, FNone);
        frame("to_follow", 8'h23, 8'h10, 8'h33, FGood);

        // Byte arriving on the would-be timeout cycle wins
        step("race_sync", 1'b1, 8'hA5, FNone);
        step("race_addr", 1'b1, 8'h23, FNone);
        for (int i = 1; i <= 9; i++) step("race_idle", 1'b0, 8'h00, FNone);
        step("race_data", 1'b1, 8'h10, FNone);
        e_addr = 8'h23;
        e_data = 8'h10;
        e_fc   = e_fc + 8'd1;
        step("race_chk", 1'b1, 8'h33, FGood);

        // Long idle in IDLE never times out
        for (int i = 0; i < 12; i++) step("idle_quiet", 1'b0, 8'h00, FNone);

        // Garbage before sync is dropped silently
        step("garbage_00", 1'b1, 8'h00, FNone);
        step("garbage_ff", 1'b1, 8'hFF, FNone);
        frame("garbage_frame", 8'h24, 8'h01, 8'h25, FGood);

        // Reset mid-frame: no strobe, everything cleared
        step("rst_sync", 1'b1, 8'hA5, FNone);
        step("rst_addr", 1'b1, 8'h24, FNone);
        RST      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        @(posedge SYS_CLK);
        #1;
        e_addr = 8'h00;
        e_data = 8'h00;
        e_fc   = 8'h00;
        check("rst_mid_frame", FNone);
        RST = 1'b0;
        step("rst_after_25", 1'b1, 8'h25, FNone);
        frame("post_rst", 8'h21, 8'h64, 8'h85, FGood);

        // frame_cnt wraps 255 -> 0
        for (int i = 0; i < 255; i++) frame("wrap", 8'h22, 8'h01, 8'h23, FGood);
        check("wrap_zero_model", FGood);
        step("wrap_drop", 1'b0, 8'h00, FNone);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
